// File: rtl/instr_fetch_unit.sv
// Purpose: RV32I fetch stage; owns the PC, fetches words over req/ack and redirects on branch/JALR.
// Latency: one cycle IDLE->FETCH, then >=1 cycle until ack; instruction presented in HOLD the cycle after ack.
// Backpressure: stall holds HOLD (instruction, pc, redirect ignored); imem ack timeout/misaligned target -> sticky error + HALT.
// Optional build macro IFU_FETCH_CNT_EN adds the 32-bit fetch_cnt consumed-instruction counter port.
`timescale 1ns/1ps

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory handshake
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // downstream controls and operands
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jalr,
  input  logic [31:0] imm_32,
  input  logic [31:0] rs1_data,
  // presented instruction
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic        fetch_err
`ifdef IFU_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  // NOP (addi x0,x0,0) shown to decode while nothing has been fetched yet.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // The timeout counter is 8 bits wide, enough for the full 1..255 range.
  // TMO_LAST is the count at which the next ack-less FETCH cycle is the
  // IMEM_TIMEOUT-th one, so the error fires after exactly IMEM_TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(IMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  tmo_cnt;
  logic [31:0] jalr_sum;
  logic [31:0] next_pc;
  logic        target_misaligned;

  // Control strobes produced by the FSM decode and consumed by the datapath.
  logic        latch_instr;
  logic        load_pc;
  logic        tmo_clr;
  logic        tmo_inc;
  logic        set_fetch_err;
  logic        set_misalign;
  logic        consume;

  // The request address is always the current PC; link value is pc+4 (wraps).
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Next-PC selection: JALR wins over branch, otherwise fall through to pc+4.
  always_comb begin
    jalr_sum = rs1_data + imm_32;
    next_pc  = pc + 32'd4;
    if (jalr) begin
      next_pc = jalr_sum & 32'hFFFF_FFFE;
    end else if (branch_taken) begin
      next_pc = pc + imm_32;
    end
    target_misaligned = |next_pc[1:0];
  end

  // State register; reset aborts any outstanding request immediately since
  // imem_req is decoded from the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state    = state;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    latch_instr   = 1'b0;
    load_pc       = 1'b0;
    tmo_clr       = 1'b0;
    tmo_inc       = 1'b0;
    set_fetch_err = 1'b0;
    set_misalign  = 1'b0;
    consume       = 1'b0;

    case (state)
      IDLE: begin
        next_state = FETCH;
      end

      FETCH: begin
        // stall is deliberately ignored here: an ack is always accepted.
        imem_req = 1'b1;
        if (imem_ack) begin
          latch_instr = 1'b1;
          next_state  = HOLD;
        end else if (tmo_cnt == TMO_LAST) begin
          set_fetch_err = 1'b1;
          next_state    = HALT;
        end else begin
          tmo_inc = 1'b1;
        end
      end

      HOLD: begin
        instr_valid = 1'b1;
        if (!stall) begin
          if (target_misaligned) begin
            // Keep the faulting instruction's PC for debug; stop fetching.
            set_misalign = 1'b1;
            next_state   = HALT;
          end else begin
            load_pc    = 1'b1;
            tmo_clr    = 1'b1;
            consume    = 1'b1;
            next_state = FETCH;
          end
        end
      end

      HALT: begin
        // Terminal until reset.
        next_state = HALT;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Program counter: only moves on an accepted, aligned consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load_pc) begin
      pc <= next_pc;
    end
  end

  // Instruction word: only changes on an accepted ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_INSTR;
    end else if (latch_instr) begin
      instruction <= imem_rdata;
    end
  end

  // Ack timeout counter: cleared per new fetch, counts ack-less FETCH cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
    end else if (tmo_clr) begin
      tmo_cnt <= 8'd0;
    end else if (tmo_inc) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Sticky error flags; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
      fetch_err    <= 1'b0;
    end else begin
      if (set_misalign) begin
        misalign_err <= 1'b1;
      end
      if (set_fetch_err) begin
        fetch_err <= 1'b1;
      end
    end
  end

`ifdef IFU_FETCH_CNT_EN
  // Consumed-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
    end else if (consume) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`else
  // Without the counter the consume strobe has no sink.
  logic unused_consume;
  assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic        jalr;
  logic [31:0] imm_32;
  logic [31:0] rs1_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign_err;
  logic        fetch_err;
`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  instr_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jalr         (jalr),
    .imm_32       (imm_32),
    .rs1_data     (rs1_data),
    .instruction  (instruction),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err),
    .fetch_err    (fetch_err)
`ifdef IFU_FETCH_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Memory image: word at 0 is addi x1,x0,5; others derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one HOLD-cycle consume; optionally record the fetch it must cause.
  task automatic consume(input logic br, input logic jr, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] nxt, input bit push_exp);
    stall        = 1'b0;
    branch_taken = br;
    jalr         = jr;
    imm_32       = imm;
    rs1_data     = rs1;
    if (push_exp) sb.push_back({nxt, mem_word(nxt)});
    tick();
    stall        = 1'b1;
    branch_taken = 1'b0;
    jalr         = 1'b0;
    imm_32       = 32'd0;
    rs1_data     = 32'd0;
  endtask

  // Answer the pending request after lat FETCH cycles, then check the
  // presented instruction against the scoreboard head.
  task automatic do_fetch(input string tag, input int lat);
    exp_t e;
    int   waited = 0;
    while (imem_req !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    check1({tag, ".req"}, imem_req, 1'b1);
    if (sb.size() > 0) check({tag, ".addr"}, imem_addr, sb[0].pc);
    if (imem_req === 1'b1) begin
      repeat (lat - 1) tick();
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    check1({tag, ".valid"}, instr_valid, 1'b1);
    check1({tag, ".req_off"}, imem_req, 1'b0);
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s.sb: observed empty scoreboard expected one entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".pc"}, pc, e.pc);
      check({tag, ".instr"}, instruction, e.instr);
      check({tag, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = 32'hDEAD_BEEF;
    stall        = 1'b1;
    branch_taken = 1'b0;
    jalr         = 1'b0;
    imm_32       = 32'd0;
    rs1_data     = 32'd0;

    // Reset state
    #12;
    check("rst.pc", pc, 32'h0);
    check("rst.instr", instruction, 32'h0000_0013);
    check("rst.pc_plus4", pc_plus4, 32'h4);
    check1("rst.valid", instr_valid, 1'b0);
    check1("rst.req", imem_req, 1'b0);
    check1("rst.misalign", misalign_err, 1'b0);
    check1("rst.fetch_err", fetch_err, 1'b0);
    tick();
    rst = 1'b0;
    check1("idle.req", imem_req, 1'b0);

    // First fetch, ack on the second FETCH cycle
    sb.push_back({32'h0, mem_word(32'h0)});
    tick();
    check1("fetch0.req", imem_req, 1'b1);
    check("fetch0.addr", imem_addr, 32'h0);
    do_fetch("f0", 2);

    // Sequential fetches 4, 8
    consume(1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b1);
    do_fetch("f4", 1);
    consume(1'b0, 1'b0, 32'h0, 32'h0, 32'h8, 1'b1);
    do_fetch("f8", 1);

    // Backward branch 8 + (-8) -> 0
    consume(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b1);
`ifdef IFU_FETCH_CNT_EN
    check("cnt3", fetch_cnt, 32'd3);
`endif
    do_fetch("br0", 3);

    // JALR beats branch: (0x101 + 0x20) & ~1 = 0x120
    consume(1'b1, 1'b1, 32'h20, 32'h101, 32'h120, 1'b1);
    do_fetch("jalr", 1);

    // Stall for 5 cycles while branch_taken toggles
    for (int i = 0; i < 5; i++) begin
      stall        = 1'b1;
      branch_taken = ~branch_taken;
      imm_32       = 32'h40;
      tick();
      check("stall.pc", pc, 32'h120);
      check("stall.instr", instruction, mem_word(32'h120));
      check1("stall.req", imem_req, 1'b0);
      check1("stall.valid", instr_valid, 1'b1);
    end
    branch_taken = 1'b0;
    consume(1'b0, 1'b0, 32'h0, 32'h0, 32'h124, 1'b1);
    do_fetch("unstall", 1);

    // Wrap: jump to FFFF_FFFC, then pc+4 wraps to 0
    consume(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    do_fetch("top", 2);
    consume(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    do_fetch("wrap", 1);

    // Misaligned branch target from pc=4
    consume(1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b1);
    do_fetch("pre_mis", 1);
    consume(1'b1, 1'b0, 32'h2, 32'h0, 32'h6, 1'b0);
    check1("mis.err", misalign_err, 1'b1);
    check("mis.pc", pc, 32'h4);
    check1("mis.valid", instr_valid, 1'b0);
    check1("mis.fetch_err", fetch_err, 1'b0);
`ifdef IFU_FETCH_CNT_EN
    check("mis.cnt", fetch_cnt, 32'd8);
`endif
    for (int i = 0; i < 4; i++) begin
      check1("halt.req", imem_req, 1'b0);
      tick();
    end
    check1("halt.err_sticky", misalign_err, 1'b1);

    // Asynchronous reset out of HALT
    #3;
    rst = 1'b1;
    #1;
    check1("rst2.misalign", misalign_err, 1'b0);
    check("rst2.pc", pc, 32'h0);
`ifdef IFU_FETCH_CNT_EN
    check("rst2.cnt", fetch_cnt, 32'd0);
`endif
    tick();
    rst = 1'b0;
    sb.push_back({32'h0, mem_word(32'h0)});
    tick();
    do_fetch("r2f0", 1);

    // Reset mid-FETCH of pc=4 drops the request at once
    consume(1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
    check1("mid.req", imem_req, 1'b1);
    check("mid.addr", imem_addr, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check1("mid.req_drop", imem_req, 1'b0);
    check("mid.pc", pc, 32'h0);
    check1("mid.valid", instr_valid, 1'b0);

    // Late ack arriving while IDLE is ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    rst = 1'b0;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("late.instr", instruction, 32'h0000_0013);
    check1("late.valid", instr_valid, 1'b0);
    check1("late.req", imem_req, 1'b1);

    // Timeout: 4 ack-less FETCH cycles -> fetch_err, HALT
    repeat (3) tick();
    check1("tmo.early_err", fetch_err, 1'b0);
    check1("tmo.early_req", imem_req, 1'b1);
    tick();
    check1("tmo.err", fetch_err, 1'b1);
    check1("tmo.req", imem_req, 1'b0);
    check1("tmo.valid", instr_valid, 1'b0);
    repeat (3) tick();
    check1("tmo.halt_req", imem_req, 1'b0);
    check1("tmo.sticky", fetch_err, 1'b1);
    check("tmo.pc", pc, 32'h0);
    check("tmo.instr", instruction, 32'h0000_0013);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream stage of the immediate generator and decoder in the RV32I core. It holds the PC, requests instruction words from instruction memory over a req/ack handshake, and presents the fetched `instruction` and its `pc` to decode and immediate generation. It computes the next PC from the redirect controls plus the `imm_32` and `rs1_data` returned by downstream stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and the first fetch address.
IMEM_TIMEOUT, 16, max cycles to wait for `imem_ack` before flagging `fetch_err`; range 1..255.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
imem_req  out  1  fetch request, held until ack
imem_addr  out  32  word address of request; always equals `pc`
imem_ack  in  1  memory has returned data this cycle
imem_rdata  in  32  instruction word, valid with `imem_ack`
stall  in  1  downstream not ready; hold current instruction
branch_taken  in  1  redirect to pc+imm_32 (B-type, JAL)
jalr  in  1  redirect to (rs1_data+imm_32)&~1; priority over `branch_taken`
imm_32  in  32  sign-extended immediate from immediate generator
rs1_data  in  32  register-file operand for JALR
instruction  out  32  latched instruction word
pc  out  32  address of `instruction`
pc_plus4  out  32  pc+4, for link writeback
instr_valid  out  1  `instruction` and `pc` valid
misalign_err  out  1  sticky: computed target not 4-byte aligned
fetch_err  out  1  sticky: ack timeout

Behaviour:
- Reset (async, active-high):
  - `pc`=RESET_PC; `instruction`=32'h0000_0013 (NOP).
  - `instr_valid`=0, `imem_req`=0.
  - `misalign_err`=0, `fetch_err`=0.
  - Timeout counter=0; state=IDLE.
- States: IDLE, FETCH, HOLD, HALT.
- IDLE:
  - Next cycle goes to FETCH.
  - `imem_req`=0.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`: latch `imem_rdata` into `instruction`, set `instr_valid`=1, go to HOLD.
  - Ack takes effect in the same cycle it is sampled; minimum fetch latency is 1 cycle after entering FETCH.
  - Timeout counter increments each cycle without ack. Reaching IMEM_TIMEOUT sets `fetch_err`=1 and goes to HALT.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0.
  - Downstream samples `jalr`, `branch_taken`, `imm_32` and `rs1_data` combinationally this cycle.
  - If `stall`=1: all state held and redirect inputs ignored.
  - If `stall`=0 (consume): compute next_pc.
    - `jalr`: (rs1_data+imm_32) & 32'hFFFF_FFFE.
    - Else `branch_taken`: pc+imm_32.
    - Else: pc+4.
  - All adds are 32-bit, wrap modulo 2^32 (pc=FFFF_FFFC +4 → 0000_0000).
  - If next_pc[1:0]≠0: set `misalign_err`=1, keep `pc`, drop `instr_valid`, go to HALT.
  - Otherwise: `pc`←next_pc, `instr_valid`←0, go to FETCH, timeout counter←0.
- HALT:
  - `instr_valid`=0, `imem_req`=0.
  - Left only by reset.
- Output relations:
  - `pc_plus4` is always `pc`+4, combinational.
  - `instruction` changes only on an accepted ack.
- `stall` during FETCH has no effect; the ack is still accepted.
- Reset asserted mid-FETCH aborts the request immediately (`imem_req`=0 asynchronously). A late ack after reset is ignored because state is IDLE.

Optional Feature:
- Macro: IFU_FETCH_CNT_EN.
- When defined:
  - Adds output `fetch_cnt`, 32 bits.
  - Counts instructions consumed (HOLD with `stall`=0 and aligned target).
  - Reset to 0; wraps at 2^32.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, ack on the 2nd FETCH cycle with rdata=32'h00500093 → `imem_addr`=0, then `instruction`=00500093, `instr_valid`=1, `pc`=0, `pc_plus4`=4.
- Sequential: consume with no redirect, 3 fetches → `pc` sequence 0,4,8. With IFU_FETCH_CNT_EN, `fetch_cnt`=3 after the third consume.
- Branch: pc=8, `branch_taken`=1, imm_32=32'hFFFF_FFF8 → next fetch at 0. `jalr`=1 and `branch_taken`=1 together, rs1=0x101, imm=0x20 → fetch 0x120.
- Stall: `stall`=1 for 5 cycles in HOLD while `branch_taken` toggles → `pc` and `instruction` unchanged, `imem_req`=0. Release with no redirect → pc+4.
- Misalign: pc=4, `branch_taken`=1, imm=32'h2 → `misalign_err`=1, `pc`=4, `instr_valid`=0, no further `imem_req` until reset.
- Timeout/reset: IMEM_TIMEOUT=4, never ack → `fetch_err`=1 after 4 FETCH cycles, HALT. Assert `rst` mid-FETCH in a separate run → `imem_req` drops the same cycle and `pc`=RESET_PC.
